tlc_light_monitor: RTL and testbench

TLC_LIGHT_MONITOR -- requirements
Module: tlc_light_monitor

---
 rtl/tlc_light_monitor.sv | 190 +++++++++++++++++++
 tb/tb_tlc_light_monitor.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/tlc_light_monitor.sv
// tlc_light_monitor
//   Passive checker for a four-lamp traffic light controller. Lamp codes are
//   001 green, 010 yellow, 100 red. Sticky error flags are raised one clock
//   after the offending inputs are presented and are cleared by err_clr.
//   The main lights M1 and M2 are sequence-tracked; MT and S are only checked
//   for legal encoding and for a green conflict with S.
//
// Optional feature macro: TLC_MON_STUCK_EN enables the stuck-lamp watchdog
// (err_stuck). Without it err_stuck is tied to 0.
//
// Parameters
//   YEL_MIN    minimum legal yellow dwell, in clock cycles
//   STUCK_MAX  cycles without any lamp change before err_stuck (watchdog only)
//
// Ports
//   clk                      clock, rising edge
//   rst                      asynchronous reset, active low
//   light_M1/M2/MT/S [2:0]   lamp codes
//   err_clr                  synchronous clear of all sticky flags
//   err_onehot               a lamp code is not 001/010/100
//   err_conflict             S green together with M1 or M2 green
//   err_seq                  illegal colour order on M1 or M2
//   err_dwell                M1 or M2 yellow shorter than YEL_MIN
//   err_stuck                no lamp change for STUCK_MAX cycles
//   err_pulse                one-cycle strobe when any flag rises
//   cycle_cnt [7:0]          completed M1 red-to-green transitions (wraps)

module tlc_light_monitor #(
    parameter int YEL_MIN   = 3,
    parameter int STUCK_MAX = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light_M1,
    input  logic [2:0] light_M2,
    input  logic [2:0] light_MT,
    input  logic [2:0] light_S,
    input  logic       err_clr,
    output logic       err_onehot,
    output logic       err_conflict,
    output logic       err_seq,
    output logic       err_dwell,
    output logic       err_stuck,
    output logic       err_pulse,
    output logic [7:0] cycle_cnt
);

    if (YEL_MIN < 1 || YEL_MIN > 16) begin : g_yel_chk
        $error("YEL_MIN must be in 1..16");
    end
    if (STUCK_MAX < 1 || STUCK_MAX > 63) begin : g_stuck_chk
        $error("STUCK_MAX must be in 1..63");
    end

    typedef enum logic [1:0] {UNK, GRN, YEL, RED} trk_t;

    typedef struct packed {
        trk_t       st;
        logic [3:0] dwell;
        logic       seq;
        logic       dwl;
    } trk_res_t;

    function automatic logic code_ok(input logic [2:0] code);
        return (code == 3'b001) || (code == 3'b010) || (code == 3'b100);
    endfunction

    // Next tracker state, next dwell count and the errors seen on this step.
    // Entry from UNK is never sequence- or dwell-checked; an illegal code
    // drops the tracker to UNK silently.
    function automatic trk_res_t trk_step(input trk_t st, input logic [3:0] dwell,
                                          input logic [2:0] code);
        trk_res_t r;
        trk_t     tgt;
        r.st    = st;
        r.dwell = dwell;
        r.seq   = 1'b0;
        r.dwl   = 1'b0;
        case (code)
            3'b001:  tgt = GRN;
            3'b010:  tgt = YEL;
            3'b100:  tgt = RED;
            default: tgt = UNK;
        endcase
        r.st = tgt;
        if (tgt != UNK) begin
            if (st != UNK && tgt != st)
                r.seq = !((st == GRN && tgt == YEL) ||
                          (st == YEL && tgt == RED) ||
                          (st == RED && tgt == GRN));
            // dwell holds (yellow cycles - 1) so the exit check adds one back
            if (st == YEL && tgt != YEL)
                r.dwl = ({1'b0, dwell} + 5'd1) < 5'(YEL_MIN);
            if (tgt == YEL)
                r.dwell = (st != YEL) ? '0 : ((dwell == 4'hF) ? dwell : dwell + 4'd1);
        end
        return r;
    endfunction

    logic       valid_q;
    trk_t       trk1, trk2;
    logic [3:0] dwell1, dwell2;
    logic [3:0] flags;      // {onehot, conflict, seq, dwell}
    logic [3:0] set;
    trk_res_t   r1, r2;
    logic       m1_rg;
    logic       stuck_set;
    logic       stuck_rise;

    always_comb begin
        r1     = trk_step(trk1, dwell1, light_M1);
        r2     = trk_step(trk2, dwell2, light_M2);
        m1_rg  = (trk1 == RED) && (light_M1 == 3'b001);
        set[3] = !(code_ok(light_M1) && code_ok(light_M2) &&
                   code_ok(light_MT) && code_ok(light_S));
        set[2] = (light_S == 3'b001) && (light_M1 == 3'b001 || light_M2 == 3'b001);
        set[1] = r1.seq | r2.seq;
        set[0] = r1.dwl | r2.dwl;
    end

    assign err_onehot   = flags[3];
    assign err_conflict = flags[2];
    assign err_seq      = flags[1];
    assign err_dwell    = flags[0];

`ifdef TLC_MON_STUCK_EN
    // prev only matters for change detection, which only the watchdog needs
    logic [11:0] prev;
    logic [5:0]  stuck_cnt, stuck_cnt_n;
    logic        stuck_q;

    always_comb begin
        if ({light_M1, light_M2, light_MT, light_S} != prev)
            stuck_cnt_n = '0;
        else if (stuck_cnt == 6'(STUCK_MAX))
            stuck_cnt_n = stuck_cnt;
        else
            stuck_cnt_n = stuck_cnt + 6'd1;
        stuck_set  = (stuck_cnt_n == 6'(STUCK_MAX));
        stuck_rise = stuck_set & ~stuck_q;
    end

    assign err_stuck = stuck_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev      <= '0;
            stuck_cnt <= '0;
            stuck_q   <= 1'b0;
        end else begin
            prev <= {light_M1, light_M2, light_MT, light_S};
            if (valid_q) begin
                stuck_cnt <= stuck_cnt_n;
                stuck_q   <= stuck_set | (stuck_q & ~err_clr);
            end
        end
    end
`else
    assign stuck_set  = 1'b0;
    assign stuck_rise = 1'b0;
    assign err_stuck  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= 1'b0;
            trk1      <= UNK;
            trk2      <= UNK;
            dwell1    <= '0;
            dwell2    <= '0;
            flags     <= '0;
            err_pulse <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            valid_q <= 1'b1;
            if (valid_q) begin
                trk1   <= r1.st;
                trk2   <= r2.st;
                dwell1 <= r1.dwell;
                dwell2 <= r2.dwell;
                if (m1_rg)
                    cycle_cnt <= cycle_cnt + 8'd1;
                // a rising condition wins over err_clr in the same cycle
                flags     <= set | (flags & ~{4{err_clr}});
                err_pulse <= (|(set & ~flags)) | stuck_rise;
            end
        end
    end

endmodule

// File: tb/tb_tlc_light_monitor.sv
// tb_tlc_light_monitor
//   Directed bench for tlc_light_monitor: a table of one-cycle vectors with
//   hand-computed flag/count expectations, then hand-written sequences for
//   the long legal loop, asynchronous reset, first-sample behaviour and the
//   stuck watchdog (expectation follows TLC_MON_STUCK_EN).

module tb_tlc_light_monitor;

    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;

`ifdef TLC_MON_STUCK_EN
    localparam logic STK_EXP = 1'b1;
`else
    localparam logic STK_EXP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] m1 = G, m2 = G, mt = R, s = R;
    logic       clr = 1'b0;
    logic       err_onehot, err_conflict, err_seq, err_dwell, err_stuck, err_pulse;
    logic [7:0] cycle_cnt;

    int errors = 0;
    int checks = 0;

    tlc_light_monitor #(.YEL_MIN(3), .STUCK_MAX(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .light_M1     (m1),
        .light_M2     (m2),
        .light_MT     (mt),
        .light_S      (s),
        .err_clr      (clr),
        .err_onehot   (err_onehot),
        .err_conflict (err_conflict),
        .err_seq      (err_seq),
        .err_dwell    (err_dwell),
        .err_stuck    (err_stuck),
        .err_pulse    (err_pulse),
        .cycle_cnt    (cycle_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] m1, m2, mt, s;
        logic       clr;
        logic [4:0] fl;     // {onehot, conflict, seq, dwell, pulse}
        logic [7:0] cnt;
    } vec_t;

    vec_t tv[36];

    function automatic vec_t mk(input logic [2:0] a, input logic [2:0] b,
                                input logic [2:0] c, input logic [2:0] d,
                                input logic e, input logic [4:0] f,
                                input logic [7:0] n);
        vec_t v;
        v.m1 = a; v.m2 = b; v.mt = c; v.s = d; v.clr = e; v.fl = f; v.cnt = n;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present inputs, let one rising edge pass, settle 1 time unit after it.
    task automatic apply(input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] c, input logic [2:0] d, input logic e);
        m1 = a; m2 = b; mt = c; s = d; clr = e;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        m1 = G; m2 = G; mt = R; s = R; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    int pulses;

    initial begin
        tv[0]  = mk(G, G, R, R, 0, 5'b00000, 0);
        tv[1]  = mk(G, G, R, R, 0, 5'b00000, 0);
        tv[2]  = mk(G, Y, R, R, 0, 5'b00000, 0);
        tv[3]  = mk(G, Y, R, R, 0, 5'b00000, 0);
        tv[4]  = mk(G, Y, R, R, 0, 5'b00000, 0);
        tv[5]  = mk(G, R, R, R, 0, 5'b00000, 0);
        tv[6]  = mk(Y, R, R, R, 0, 5'b00000, 0);
        tv[7]  = mk(Y, R, R, R, 0, 5'b00000, 0);
        tv[8]  = mk(Y, R, R, R, 0, 5'b00000, 0);
        tv[9]  = mk(R, R, R, R, 0, 5'b00000, 0);
        tv[10] = mk(R, R, R, G, 0, 5'b00000, 0);
        tv[11] = mk(G, G, R, R, 0, 5'b00000, 1);
        tv[12] = mk(G, 3'b011, R, R, 0, 5'b10001, 1);
        tv[13] = mk(G, G, R, R, 0, 5'b10000, 1);
        tv[14] = mk(G, G, R, R, 1, 5'b00000, 1);
        tv[15] = mk(G, G, R, G, 1, 5'b01001, 1);
        tv[16] = mk(G, G, R, R, 0, 5'b01000, 1);
        tv[17] = mk(G, G, R, R, 1, 5'b00000, 1);
        tv[18] = mk(R, G, R, R, 0, 5'b00101, 1);
        tv[19] = mk(G, G, R, R, 0, 5'b00100, 2);
        tv[20] = mk(G, Y, R, R, 0, 5'b00100, 2);
        tv[21] = mk(G, Y, R, R, 0, 5'b00100, 2);
        tv[22] = mk(G, R, R, R, 0, 5'b00111, 2);
        tv[23] = mk(G, R, R, R, 1, 5'b00000, 2);
        tv[24] = mk(3'b101, G, R, G, 0, 5'b11001, 2);
        tv[25] = mk(G, G, R, R, 0, 5'b11000, 2);
        tv[26] = mk(G, G, R, R, 1, 5'b00000, 2);
        tv[27] = mk(G, Y, R, R, 0, 5'b00000, 2);
        tv[28] = mk(G, 3'b111, R, R, 0, 5'b10001, 2);
        tv[29] = mk(G, R, R, R, 0, 5'b10000, 2);
        tv[30] = mk(G, R, R, R, 1, 5'b00000, 2);
        tv[31] = mk(G, Y, R, R, 0, 5'b00101, 2);
        tv[32] = mk(G, Y, R, R, 0, 5'b00100, 2);
        tv[33] = mk(G, Y, R, R, 0, 5'b00100, 2);
        tv[34] = mk(G, G, R, R, 0, 5'b00100, 2);
        tv[35] = mk(G, G, 3'b000, R, 1, 5'b10001, 2);

        // reset state
        #2;
        chk("reset_flags", {3'b0, err_onehot, err_conflict, err_seq, err_dwell, err_pulse}, 8'h00);
        chk("reset_stuck", {7'b0, err_stuck}, 8'h00);
        chk("reset_cnt", cycle_cnt, 8'h00);

        do_reset();
        for (int i = 0; i < 36; i++) begin
            apply(tv[i].m1, tv[i].m2, tv[i].mt, tv[i].s, tv[i].clr);
            chk($sformatf("vec%0d_onehot", i),   {7'b0, err_onehot},   {7'b0, tv[i].fl[4]});
            chk($sformatf("vec%0d_conflict", i), {7'b0, err_conflict}, {7'b0, tv[i].fl[3]});
            chk($sformatf("vec%0d_seq", i),      {7'b0, err_seq},      {7'b0, tv[i].fl[2]});
            chk($sformatf("vec%0d_dwell", i),    {7'b0, err_dwell},    {7'b0, tv[i].fl[1]});
            chk($sformatf("vec%0d_pulse", i),    {7'b0, err_pulse},    {7'b0, tv[i].fl[0]});
            chk($sformatf("vec%0d_stuck", i),    {7'b0, err_stuck},    8'h00);
            chk($sformatf("vec%0d_cnt", i),      cycle_cnt,            tv[i].cnt);
        end

        // 300 legal loops plus one closing green: 300 red->green on M1, wraps to 44
        do_reset();
        pulses = 0;
        for (int l = 0; l < 300; l++) begin
            for (int c = 0; c < 8; c++) begin apply(G, G, R, R, 0); pulses += int'(err_pulse); end
            for (int c = 0; c < 3; c++) begin apply(G, Y, R, R, 0); pulses += int'(err_pulse); end
            for (int c = 0; c < 6; c++) begin apply(Y, R, R, R, 0); pulses += int'(err_pulse); end
            for (int c = 0; c < 4; c++) begin apply(R, R, R, G, 0); pulses += int'(err_pulse); end
        end
        apply(G, G, R, R, 0);
        pulses += int'(err_pulse);
        chk("loop_pulses", 8'(pulses), 8'h00);
        chk("loop_flags", {3'b0, err_onehot, err_conflict, err_seq, err_dwell, err_stuck}, 8'h00);
        chk("loop_cnt", cycle_cnt, 8'd44);

        // asynchronous reset mid-run, with a flag set and a non-zero count
        apply(3'b000, G, R, R, 0);
        chk("pre_rst_onehot", {7'b0, err_onehot}, 8'h01);
        chk("pre_rst_pulse", {7'b0, err_pulse}, 8'h01);
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst_flags", {2'b0, err_onehot, err_conflict, err_seq, err_dwell, err_stuck, err_pulse}, 8'h00);
        chk("async_rst_cnt", cycle_cnt, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // first post-reset sample only loads history
        apply(3'b000, G, R, R, 0);
        chk("first_sample_onehot", {7'b0, err_onehot}, 8'h00);
        apply(3'b000, G, R, R, 0);
        chk("second_sample_onehot", {7'b0, err_onehot}, 8'h01);

        // frozen inputs: watchdog trips only when enabled
        do_reset();
        for (int c = 0; c < 20; c++) apply(G, G, R, R, 0);
        chk("stuck_early", {7'b0, err_stuck}, 8'h00);
        for (int c = 0; c < 20; c++) apply(G, G, R, R, 0);
        chk("stuck_late", {7'b0, err_stuck}, {7'b0, STK_EXP});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout: got running expected finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
